commit_ctrl: RTL and testbench
==============================

// Module: commit_ctrl
// PURPOSE
//  Retire stage directly downstream of the ROB status logic. Consumes the per-cycle commit
//  stream (commit_e_, flush_, com_pc/rd/exp_/exp_code/rob_id). Releases committed
//  destinations to the register-map, counts retired instructions (instret), and sequences
//  precise exception entry: save EPC/cause, redirect fetch to the trap vector, hold fetch
//  while the pipeline drains.
// PARAMETERS
//  ADDR       `AddrWidth  PC / trap-vector width
//  ROB_DEPTH  `RobDepth   ROB entries; ROB = $clog2(ROB_DEPTH)
//  CNT        64          instret counter width
//  DRAIN_CYC  2           cycles fetch is held after redirect (>=1)
// PORTS
//  clk            in   1        clock
//  reset_         in   1        async active-low reset
//  commit_e_      in   1        head entry commits this cycle (low = commit)
//  flush_         in   1        ROB flush (low = flush)
//  com_pc         in   ADDR     committing PC
//  com_rd         in   RegFile_t  committing destination
//  com_exp_       in   1        committing instruction raised exception (low)
//  com_exp_code   in   ExpCode_t  exception cause
//  com_rob_id     in   ROB      committing ROB index
//  tvec           in   ADDR     trap vector base (from CSR)
//  ret_e_         out  1        register-map release strobe (low)
//  ret_rd         out  RegFile_t  released destination
//  ret_rob_id     out  ROB      released ROB index
//  trap_e_        out  1        fetch redirect strobe (low), one cycle
//  trap_pc        out  ADDR     redirect target
//  epc            out  ADDR     saved exception PC (registered)
//  cause          out  ExpCode_t  saved cause (registered)
//  fetch_hold     out  1        high: fetch must not issue
//  instret        out  CNT      retired-instruction count
// BEHAVIOUR
//  Reset: state IDLE; ret_e_/trap_e_ high; ret_rd=0, ret_rob_id=0, trap_pc=0, epc=0,
//   cause=EXP_I_MISS_ALIGN; fetch_hold=0; instret=0. Reset mid-sequence aborts to IDLE.
//  All outputs registered; retire/trap actions appear 1 cycle after the commit input.
//  States: IDLE -> SAVE -> REDIRECT -> DRAIN -> IDLE.
//  IDLE, commit_e_=0, com_exp_=1: ret_e_=0 next cycle with ret_rd=com_rd,
//   ret_rob_id=com_rob_id; instret += 1 (wraps modulo 2^CNT, no saturation).
//   A flush_=0 with com_exp_=1 (branch/jump miss) still retires normally and does not
//   enter SAVE; the redirect comes from the execute stage.
//  IDLE, commit_e_=0, com_exp_=0: no release, instret unchanged; latch epc=com_pc,
//   cause=com_exp_code; go to SAVE. Exception takes priority over a concurrent miss.
//  SAVE (1 cycle): fetch_hold=1; go to REDIRECT.
//  REDIRECT (1 cycle): trap_e_=0, trap_pc={tvec[ADDR-1:2],2'b00}; fetch_hold=1;
//   load drain counter with DRAIN_CYC-1; go to DRAIN.
//  DRAIN: fetch_hold=1; decrement counter; at 0, go to IDLE with fetch_hold=0 on exit.
//  Any commit input outside IDLE is ignored: no release, no count, no nested trap.
//  commit_e_=1: outputs return to idle values (strobes high); epc/cause hold.
//  Lower epc alignment bits are kept verbatim (EXP_I_MISS_ALIGN needs the raw PC).
// STRUCTURE
//  CommitState_t enum {CM_IDLE,CM_SAVE,CM_REDIRECT,CM_DRAIN} goes in rob.svh.
//  RegFile_t comes from regfile.svh; ExpCode_t from exception.svh.
//  One sub-module: retire_counter (CNT-bit, async-reset, enable-increment, wraps);
//  everything else stays flat in commit_ctrl.
// TESTING
//  1 Reset; commit 3 back-to-back (rd=x5,x6,x0, id 0..2) -> ret_e_ low 3 cycles,
//    1 cycle delayed, same rd/id order; instret=3.
//  2 Commit com_exp_=0, pc=0x104, code=illegal, tvec=0x203 -> epc=0x104, cause=illegal;
//    trap_e_ low exactly 1 cycle with trap_pc=0x200, 2 cycles after the input;
//    fetch_hold high 1+1+DRAIN_CYC cycles; instret unchanged.
//  3 During SAVE/DRAIN drive 4 normal commits -> no ret_e_, instret frozen, no new trap.
//  4 flush_=0 with com_exp_=1 (miss) -> normal retire, instret+1, trap_e_ stays high.
//    Same cycle with com_exp_=0 -> trap taken, no retire.
//  5 Preload instret=2^CNT-1 (force); 1 commit -> instret=0.
//  6 Assert reset_ low in DRAIN -> all outputs take reset values immediately;
//    after release, the next commit retires normally.

Source files
------------

// File: rtl/commit_ctrl_pkg.sv
// Shared types for the retire stage: register/exception encodings and the
// commit sequencer state set.
package commit_ctrl_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned RobDepth  = 16;
  localparam int unsigned RegWidth  = 5;

  typedef logic [RegWidth-1:0] RegFile_t;

  typedef enum logic [3:0] {
    EXP_I_MISS_ALIGN = 4'd0,
    EXP_I_ACC_FAULT  = 4'd1,
    EXP_ILLEGAL_INST = 4'd2,
    EXP_BREAKPOINT   = 4'd3,
    EXP_L_MISS_ALIGN = 4'd4,
    EXP_L_ACC_FAULT  = 4'd5,
    EXP_S_MISS_ALIGN = 4'd6,
    EXP_S_ACC_FAULT  = 4'd7,
    EXP_ECALL        = 4'd8
  } ExpCode_t;

  typedef enum logic [1:0] {
    CM_IDLE,
    CM_SAVE,
    CM_REDIRECT,
    CM_DRAIN
  } CommitState_t;

endpackage

// File: rtl/commit_ctrl_if.sv
// Commit stream from the ROB head and the register-map release path back to it.
interface commit_ctrl_if
  import commit_ctrl_pkg::*;
#(
  parameter int unsigned ADDR      = AddrWidth,
  parameter int unsigned ROB_DEPTH = RobDepth
) ();

  localparam int unsigned ROB = $clog2(ROB_DEPTH);

  logic            commit_e_;
  logic            flush_;
  logic [ADDR-1:0] com_pc;
  RegFile_t        com_rd;
  logic            com_exp_;
  ExpCode_t        com_exp_code;
  logic [ROB-1:0]  com_rob_id;

  logic            ret_e_;
  RegFile_t        ret_rd;
  logic [ROB-1:0]  ret_rob_id;

  modport master (
    output commit_e_, flush_, com_pc, com_rd, com_exp_, com_exp_code, com_rob_id,
    input  ret_e_, ret_rd, ret_rob_id
  );

  modport slave (
    input  commit_e_, flush_, com_pc, com_rd, com_exp_, com_exp_code, com_rob_id,
    output ret_e_, ret_rd, ret_rob_id
  );

endinterface

// File: rtl/commit_ctrl_retire_counter.sv
// Retired-instruction counter: enable-increment, wraps modulo 2^CNT.
module retire_counter #(
  parameter int unsigned CNT = 64
) (
  input  logic           clk,
  input  logic           reset_,
  input  logic           inc,
  output logic [CNT-1:0] count
);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT'(1);
    end
  end

endmodule

// File: rtl/commit_ctrl.sv
// Retire stage: releases committed destinations, counts instret and sequences
// precise exception entry (save EPC/cause, redirect to trap vector, drain).
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int unsigned ADDR      = AddrWidth,
  parameter int unsigned ROB_DEPTH = RobDepth,
  parameter int unsigned CNT       = 64,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic            clk,
  input  logic            reset_,
  commit_ctrl_if.slave    cif,
  input  logic [ADDR-1:0] tvec,
  output logic            trap_e_,
  output logic [ADDR-1:0] trap_pc,
  output logic [ADDR-1:0] epc,
  output ExpCode_t        cause,
  output logic            fetch_hold,
  output logic [CNT-1:0]  instret
);

  localparam int unsigned ROB    = $clog2(ROB_DEPTH);
  localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  CommitState_t    state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;

  logic            ret_e_q, ret_e_d;
  RegFile_t        ret_rd_q, ret_rd_d;
  logic [ROB-1:0]  ret_id_q, ret_id_d;
  logic            trap_e_q, trap_e_d;
  logic [ADDR-1:0] trap_pc_q, trap_pc_d;
  logic [ADDR-1:0] epc_q, epc_d;
  ExpCode_t        cause_q, cause_d;
  logic            hold_q, hold_d;
  logic            retire_inc;

  // A flush alone changes nothing here (the execute stage redirects on a miss),
  // and the trap vector is word-aligned, so these inputs are intentionally unread.
  logic unused_in;
  assign unused_in = ^{cif.flush_, tvec[1:0]};

  // Outputs are registered from the next-state decode, so each strobe is
  // produced while in the preceding state and appears during its own state.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    ret_e_d    = 1'b1;
    ret_rd_d   = ret_rd_q;
    ret_id_d   = ret_id_q;
    trap_e_d   = 1'b1;
    trap_pc_d  = trap_pc_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    retire_inc = 1'b0;

    unique case (state_q)
      CM_IDLE: begin
        if (!cif.commit_e_) begin
          if (!cif.com_exp_) begin
            epc_d   = cif.com_pc;
            cause_d = cif.com_exp_code;
            state_d = CM_SAVE;
          end else begin
            ret_e_d    = 1'b0;
            ret_rd_d   = cif.com_rd;
            ret_id_d   = cif.com_rob_id;
            retire_inc = 1'b1;
          end
        end
      end
      CM_SAVE: begin
        trap_e_d  = 1'b0;
        trap_pc_d = {tvec[ADDR-1:2], 2'b00};
        state_d   = CM_REDIRECT;
      end
      CM_REDIRECT: begin
        drain_d = DrainW'(DRAIN_CYC - 1);
        state_d = CM_DRAIN;
      end
      CM_DRAIN: begin
        if (drain_q == '0) begin
          state_d = CM_IDLE;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
      default: state_d = CM_IDLE;
    endcase

    hold_d = (state_d != CM_IDLE);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= CM_IDLE;
      drain_q   <= '0;
      ret_e_q   <= 1'b1;
      ret_rd_q  <= '0;
      ret_id_q  <= '0;
      trap_e_q  <= 1'b1;
      trap_pc_q <= '0;
      epc_q     <= '0;
      cause_q   <= EXP_I_MISS_ALIGN;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      ret_e_q   <= ret_e_d;
      ret_rd_q  <= ret_rd_d;
      ret_id_q  <= ret_id_d;
      trap_e_q  <= trap_e_d;
      trap_pc_q <= trap_pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      hold_q    <= hold_d;
    end
  end

  retire_counter #(
    .CNT(CNT)
  ) u_retire_counter (
    .clk   (clk),
    .reset_(reset_),
    .inc   (retire_inc),
    .count (instret)
  );

  assign cif.ret_e_     = ret_e_q;
  assign cif.ret_rd     = ret_rd_q;
  assign cif.ret_rob_id = ret_id_q;
  assign trap_e_        = trap_e_q;
  assign trap_pc        = trap_pc_q;
  assign epc            = epc_q;
  assign cause          = cause_q;
  assign fetch_hold     = hold_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Scoreboard bench for commit_ctrl: retire and trap expectations are queued at
// stimulus time and popped when the DUT strobes.
module tb_commit_ctrl;
  import commit_ctrl_pkg::*;

  localparam int unsigned ADDR      = 32;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB       = 4;
  localparam int unsigned CNT       = 8;
  localparam int unsigned DRAIN_CYC = 2;

  logic            clk = 1'b0;
  logic            reset_;
  logic [ADDR-1:0] tvec;
  logic            trap_e_;
  logic [ADDR-1:0] trap_pc;
  logic [ADDR-1:0] epc;
  ExpCode_t        cause;
  logic            fetch_hold;
  logic [CNT-1:0]  instret;

  commit_ctrl_if #(.ADDR(ADDR), .ROB_DEPTH(ROB_DEPTH)) cif ();

  commit_ctrl #(
    .ADDR(ADDR), .ROB_DEPTH(ROB_DEPTH), .CNT(CNT), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .reset_(reset_), .cif(cif.slave), .tvec(tvec),
    .trap_e_(trap_e_), .trap_pc(trap_pc), .epc(epc), .cause(cause),
    .fetch_hold(fetch_hold), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    RegFile_t       rd;
    logic [ROB-1:0] id;
  } ret_t;

  ret_t            ret_q[$];
  logic [ADDR-1:0] trap_q[$];
  int              checks = 0;
  int              errors = 0;
  logic [CNT-1:0]  exp_instret = '0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cif.commit_e_    = 1'b1;
    cif.flush_       = 1'b1;
    cif.com_exp_     = 1'b1;
    cif.com_pc       = '0;
    cif.com_rd       = '0;
    cif.com_exp_code = EXP_I_MISS_ALIGN;
    cif.com_rob_id   = '0;
  endtask

  task automatic drive_commit(input RegFile_t rd, input logic [ROB-1:0] id, input logic exp_,
                              input logic fl_, input logic [ADDR-1:0] pc, input ExpCode_t code);
    cif.commit_e_    = 1'b0;
    cif.flush_       = fl_;
    cif.com_exp_     = exp_;
    cif.com_pc       = pc;
    cif.com_rd       = rd;
    cif.com_exp_code = code;
    cif.com_rob_id   = id;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    tvec   = '0;
    drive_idle();
    cyc();
    cyc();
    checks++;
    if ({cif.ret_e_, trap_e_, fetch_hold} !== 3'b110) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 110", {cif.ret_e_, trap_e_, fetch_hold});
    end
    checks++;
    if ({cif.ret_rd, cif.ret_rob_id, trap_pc, epc, instret} !== '0 || cause !== EXP_I_MISS_ALIGN) begin
      errors++;
      $display("FAIL reset_values: rd=%0d id=%0d tpc=%h epc=%h cause=%0d instret=%0d want all 0",
               cif.ret_rd, cif.ret_rob_id, trap_pc, epc, cause, instret);
    end
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic test_back_to_back();
    RegFile_t rds[3];
    ret_t     e;
    rds[0] = 5'd5; rds[1] = 5'd6; rds[2] = 5'd0;
    for (int i = 0; i < 3; i++) begin
      drive_commit(rds[i], ROB'(i), 1'b1, 1'b1, ADDR'(32'h100 + 4 * i), EXP_I_MISS_ALIGN);
      e.rd = rds[i]; e.id = ROB'(i);
      ret_q.push_back(e);
      exp_instret++;
      cyc();
      checks++;
      if (cif.ret_e_ !== 1'b0 || ret_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_strobe[%0d]: ret_e_=%b want 0", i, cif.ret_e_);
        ret_q.delete();
      end else begin
        e = ret_q.pop_front();
        checks++;
        if (cif.ret_rd !== e.rd || cif.ret_rob_id !== e.id) begin
          errors++;
          $display("FAIL b2b_data[%0d]: rd=%0d id=%0d want rd=%0d id=%0d",
                   i, cif.ret_rd, cif.ret_rob_id, e.rd, e.id);
        end
      end
    end
    drive_idle();
    cyc();
    checks++;
    if (cif.ret_e_ !== 1'b1 || trap_e_ !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: ret_e_=%b trap_e_=%b want 1 1", cif.ret_e_, trap_e_);
    end
    checks++;
    if (instret !== exp_instret) begin
      errors++;
      $display("FAIL b2b_instret: got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_trap();
    int hold_cnt = 0;
    int trap_cnt = 0;
    int trap_at  = -1;
    tvec = 32'h203;
    drive_commit(5'd7, 4'd3, 1'b0, 1'b1, 32'h104, EXP_ILLEGAL_INST);
    trap_q.push_back(32'h200);
    cyc();
    drive_idle();
    for (int k = 0; k < 7; k++) begin
      if (fetch_hold === 1'b1) hold_cnt++;
      checks++;
      if (cif.ret_e_ !== 1'b1) begin
        errors++;
        $display("FAIL trap_no_retire[%0d]: ret_e_=%b want 1", k, cif.ret_e_);
      end
      if (trap_e_ === 1'b0) begin
        trap_cnt++;
        trap_at = k;
        if (trap_q.size() != 0) begin
          checks++;
          if (trap_pc !== trap_q[0]) begin
            errors++;
            $display("FAIL trap_pc: got %h want %h", trap_pc, trap_q[0]);
          end
          void'(trap_q.pop_front());
        end
      end
      cyc();
    end
    checks++;
    if (epc !== 32'h104 || cause !== EXP_ILLEGAL_INST) begin
      errors++;
      $display("FAIL trap_save: epc=%h cause=%0d want 104 %0d", epc, cause, EXP_ILLEGAL_INST);
    end
    checks++;
    if (trap_cnt != 1 || trap_at != 1) begin
      errors++;
      $display("FAIL trap_strobe: count=%0d at=%0d want 1 at 1", trap_cnt, trap_at);
    end
    checks++;
    if (hold_cnt != 2 + DRAIN_CYC || fetch_hold !== 1'b0) begin
      errors++;
      $display("FAIL trap_hold: cycles=%0d now=%b want %0d then 0", hold_cnt, fetch_hold, 2 + DRAIN_CYC);
    end
    checks++;
    if (instret !== exp_instret || trap_q.size() != 0) begin
      errors++;
      $display("FAIL trap_instret: got %0d pending=%0d want %0d 0", instret, trap_q.size(), exp_instret);
    end
  endtask

  task automatic test_ignore_busy();
    int trap_cnt = 0;
    tvec = 32'h400;
    drive_commit(5'd1, 4'd4, 1'b0, 1'b1, 32'h208, EXP_ECALL);
    trap_q.push_back(32'h400);
    cyc();
    for (int k = 0; k < 4; k++) begin
      drive_commit(RegFile_t'(9 + k), ROB'(k), 1'b1, 1'b1, ADDR'(32'h300 + 4 * k), EXP_I_MISS_ALIGN);
      cyc();
      checks++;
      if (cif.ret_e_ !== 1'b1) begin
        errors++;
        $display("FAIL busy_no_retire[%0d]: ret_e_=%b want 1", k, cif.ret_e_);
      end
      if (trap_e_ === 1'b0) begin
        trap_cnt++;
        if (trap_q.size() != 0) begin
          checks++;
          if (trap_pc !== trap_q[0]) begin
            errors++;
            $display("FAIL busy_trap_pc: got %h want %h", trap_pc, trap_q[0]);
          end
          void'(trap_q.pop_front());
        end
      end
    end
    drive_idle();
    cyc();
    checks++;
    if (cif.ret_e_ !== 1'b1 || trap_e_ !== 1'b1 || fetch_hold !== 1'b0 || trap_cnt != 1) begin
      errors++;
      $display("FAIL busy_after: ret_e_=%b trap_e_=%b hold=%b traps=%0d want 1 1 0 1",
               cif.ret_e_, trap_e_, fetch_hold, trap_cnt);
    end
    checks++;
    if (instret !== exp_instret || epc !== 32'h208 || cause !== EXP_ECALL) begin
      errors++;
      $display("FAIL busy_state: instret=%0d epc=%h cause=%0d want %0d 208 %0d",
               instret, epc, cause, exp_instret, EXP_ECALL);
    end
  endtask

  task automatic test_flush_miss();
    ret_t e;
    int   trap_cnt = 0;
    drive_commit(5'd12, 4'd5, 1'b1, 1'b0, 32'h500, EXP_I_MISS_ALIGN);
    e.rd = 5'd12; e.id = 4'd5;
    ret_q.push_back(e);
    exp_instret++;
    cyc();
    checks++;
    if (cif.ret_e_ !== 1'b0 || trap_e_ !== 1'b1 || ret_q.size() == 0) begin
      errors++;
      $display("FAIL miss_retire: ret_e_=%b trap_e_=%b want 0 1", cif.ret_e_, trap_e_);
      ret_q.delete();
    end else begin
      e = ret_q.pop_front();
      checks++;
      if (cif.ret_rd !== e.rd || cif.ret_rob_id !== e.id || instret !== exp_instret) begin
        errors++;
        $display("FAIL miss_data: rd=%0d id=%0d instret=%0d want %0d %0d %0d",
                 cif.ret_rd, cif.ret_rob_id, instret, e.rd, e.id, exp_instret);
      end
    end
    tvec = 32'h1000;
    drive_commit(5'd13, 4'd6, 1'b0, 1'b0, 32'h33, EXP_L_ACC_FAULT);
    trap_q.push_back(32'h1000);
    cyc();
    drive_idle();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cif.ret_e_ !== 1'b1) begin
        errors++;
        $display("FAIL miss_exc_no_retire[%0d]: ret_e_=%b want 1", k, cif.ret_e_);
      end
      if (trap_e_ === 1'b0) begin
        trap_cnt++;
        if (trap_q.size() != 0) begin
          checks++;
          if (trap_pc !== trap_q[0]) begin
            errors++;
            $display("FAIL miss_exc_trap_pc: got %h want %h", trap_pc, trap_q[0]);
          end
          void'(trap_q.pop_front());
        end
      end
      cyc();
    end
    checks++;
    if (trap_cnt != 1 || epc !== 32'h33 || cause !== EXP_L_ACC_FAULT || instret !== exp_instret) begin
      errors++;
      $display("FAIL miss_exc: traps=%0d epc=%h cause=%0d instret=%0d want 1 33 %0d %0d",
               trap_cnt, epc, cause, instret, EXP_L_ACC_FAULT, exp_instret);
    end
  endtask

  task automatic test_wrap();
    ret_t e;
    int   n;
    n = (1 << CNT) - 1 - int'(exp_instret);
    for (int i = 0; i <= n; i++) begin
      if (i == n) begin
        checks++;
        if (instret !== {CNT{1'b1}}) begin
          errors++;
          $display("FAIL wrap_max: got %0d want %0d", instret, (1 << CNT) - 1);
        end
      end
      drive_commit(RegFile_t'(i), ROB'(i), 1'b1, 1'b1, ADDR'(32'h2000 + 4 * i), EXP_I_MISS_ALIGN);
      e.rd = RegFile_t'(i); e.id = ROB'(i);
      ret_q.push_back(e);
      exp_instret++;
      cyc();
      checks++;
      if (cif.ret_e_ !== 1'b0 || ret_q.size() == 0) begin
        errors++;
        $display("FAIL wrap_strobe[%0d]: ret_e_=%b want 0", i, cif.ret_e_);
        ret_q.delete();
      end else begin
        e = ret_q.pop_front();
        if (cif.ret_rd !== e.rd || cif.ret_rob_id !== e.id) begin
          errors++;
          $display("FAIL wrap_data[%0d]: rd=%0d id=%0d want %0d %0d",
                   i, cif.ret_rd, cif.ret_rob_id, e.rd, e.id);
        end
      end
    end
    drive_idle();
    checks++;
    if (instret !== '0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL wrap_zero: got %0d want 0", instret);
    end
  endtask

  task automatic test_reset_in_drain();
    ret_t e;
    tvec = 32'h800;
    drive_commit(5'd2, 4'd8, 1'b0, 1'b1, 32'h610, EXP_BREAKPOINT);
    cyc();
    drive_idle();
    cyc();
    cyc();
    checks++;
    if (fetch_hold !== 1'b1 || epc !== 32'h610) begin
      errors++;
      $display("FAIL drain_reached: hold=%b epc=%h want 1 610", fetch_hold, epc);
    end
    #2;
    reset_ = 1'b0;
    #1;
    exp_instret = '0;
    ret_q.delete();
    trap_q.delete();
    checks++;
    if ({cif.ret_e_, trap_e_, fetch_hold} !== 3'b110 || epc !== '0 || trap_pc !== '0 ||
        cause !== EXP_I_MISS_ALIGN || instret !== exp_instret ||
        cif.ret_rd !== '0 || cif.ret_rob_id !== '0) begin
      errors++;
      $display("FAIL drain_reset: strobes=%b epc=%h tpc=%h cause=%0d instret=%0d want 110 0 0 0 0",
               {cif.ret_e_, trap_e_, fetch_hold}, epc, trap_pc, cause, instret);
    end
    @(negedge clk);
    reset_ = 1'b1;
    drive_commit(5'd21, 4'd9, 1'b1, 1'b1, 32'h700, EXP_I_MISS_ALIGN);
    e.rd = 5'd21; e.id = 4'd9;
    ret_q.push_back(e);
    exp_instret++;
    cyc();
    drive_idle();
    checks++;
    if (cif.ret_e_ !== 1'b0 || ret_q.size() == 0) begin
      errors++;
      $display("FAIL post_reset_strobe: ret_e_=%b want 0", cif.ret_e_);
    end else begin
      e = ret_q.pop_front();
      checks++;
      if (cif.ret_rd !== e.rd || cif.ret_rob_id !== e.id || instret !== exp_instret) begin
        errors++;
        $display("FAIL post_reset_data: rd=%0d id=%0d instret=%0d want %0d %0d %0d",
                 cif.ret_rd, cif.ret_rob_id, instret, e.rd, e.id, exp_instret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_trap();
    test_ignore_busy();
    test_flush_miss();
    test_wrap();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
